// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the serial-adder controller.
// The state encoding is shared so the bench and any future wrappers agree on it.
package serial_add_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LOAD = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and the controller.
// The controller side uses the slave modport.
interface serial_add_ctrl_if #(
  parameter int N = serial_add_pkg::DEFAULT_N
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cy;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_cy
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_cy
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// Controller that drives an external bit-serial adder: clears it, loads both operands
// LSB first, collects N sum bits plus the final carry, then holds the result until taken.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus,
  output logic              si_1,
  output logic              si_2,
  output logic              load,
  input  logic              sum_in,
  input  logic              cy_in
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  result;
  logic          carry;

  logic          xfer;
  logic          in_phase;
  logic          phase_end;

  assign xfer      = bus.in_valid && (state == IDLE);
  assign in_phase  = (state == CLR) || (state == LOAD) || (state == ADD);
  assign phase_end = in_phase && (cnt == LAST);

  // NOTE: every signal driven here gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    load          = 1'b1;
    si_1          = 1'b0;
    si_2          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = CLR;
      end
      CLR: begin
        if (phase_end) state_nx = LOAD;
      end
      LOAD: begin
        si_1 = op_a[0];
        si_2 = op_b[0];
        if (phase_end) state_nx = ADD;
      end
      ADD: begin
        load = 1'b0;
        if (phase_end) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Operands, counter and result are few bits wide, so they are all cleared on reset;
  // that is what lets an aborted operation leave nothing behind on out_sum/out_cy.
  // NOTE: unlike a RAM array, these small holding registers are reset explicitly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      if (in_phase) cnt <= phase_end ? '0 : cnt + CW'(1);
      else          cnt <= '0;

      // Operands shift right during LOAD so bit k sits in position 0 in LOAD cycle k.
      if (xfer) begin
        op_a <= bus.in_a;
        op_b <= bus.in_b;
      end else if (state == LOAD) begin
        op_a <= op_a >> 1;
        op_b <= op_b >> 1;
      end

      if (state == ADD) begin
        result <= {sum_in, result[N-1:1]};
        if (phase_end) carry <= cy_in;
      end
    end
  end

  assign bus.out_sum = result;
  assign bus.out_cy  = carry;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: N, 4, operand width in bits; sets the cycle count of each serial phase.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in_a  input  N  operand A.
REQ-007 in_b  input  N  operand B.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_sum  output  N  A+B modulo 2^N.
REQ-011 out_cy  output  1  carry-out of A+B.
REQ-012 si_1  output  1  serial operand-A bit to the serial adder.
REQ-013 si_2  output  1  serial operand-B bit to the serial adder.
REQ-014 load  output  1  adder load strobe; 1 = shift si_1 into the A register, 0 = shift the adder sum into the A register.
REQ-015 sum_in  input  1  combinational sum bit from the adder.
REQ-016 cy_in  input  1  combinational carry bit from the adder.

Function
REQ-017 FSM states: IDLE, CLR, LOAD, ADD, DONE; phase counter of clog2(N) bits.
REQ-018 in_ready = 1 only in IDLE; a transfer is in_valid && in_ready at a clock edge; in_a and in_b are latched on transfer, and later input changes are ignored.
REQ-019 IDLE -> CLR on transfer; CLR -> LOAD, LOAD -> ADD, ADD -> DONE, each after exactly N cycles.
REQ-020 CLR drives load=1, si_1=0, si_2=0; this zeroes both adder shift registers and guarantees the adder carry register is 0 before ADD.
REQ-021 LOAD drives load=1, with si_1/si_2 = latched A/B bit k in LOAD cycle k, LSB first.
REQ-022 ADD drives load=0, si_1=0, si_2=0; in ADD cycle k, sum_in is shifted into the result register (MSB entry, right shift), so result bit k = sum_in of cycle k.
REQ-023 out_cy is captured from cy_in in the last ADD cycle (k=N-1).
REQ-024 DONE: out_valid=1 with out_sum/out_cy stable until out_ready=1; on out_valid && out_ready -> IDLE.
REQ-025 No bypass: in_ready stays 0 in DONE, even in the cycle out_ready=1.
REQ-026 IDLE and DONE drive load=1, si_1=0, si_2=0.
REQ-027 Latency: transfer in cycle 0; CLR cycles 1..N, LOAD N+1..2N, ADD 2N+1..3N; out_valid=1 from cycle 3N+1 (cycle 13 for N=4).
REQ-028 Maximum throughput: one operation per 3N+2 cycles, when out_ready is tied high.
REQ-029 out_sum/out_cy hold their last result outside DONE; the result register is only written in ADD.
REQ-030 si_1, si_2, load, in_ready and out_valid are decoded from registered state only; no input-to-output combinational path.

Reset
REQ-031 rst low, at any time including mid-operation: state=IDLE, counter=0, operand and result registers=0, out_cy=0; any in-flight operation is discarded without producing a result.
REQ-032 Output values while rst is low: in_ready=1, out_valid=0, load=1, si_1=0, si_2=0, out_sum=0, out_cy=0.
REQ-033 The block relies on the adder sharing clk/rst; correct results after a mid-operation reset depend only on the CLR phase, never on adder reset state.

Structure
REQ-034 Package serial_add_pkg holds the state enum typedef and the default width constant (4).
REQ-035 Single module; no sub-module. Counter, operand shift registers and result shift register are inline.

Verification
REQ-036 The bench connects the controller to the existing 4-bit serial adder (si_1->SI_1, si_2->SI_2, load->load, Sum->sum_in, Cy->cy_in) and checks every result against a software A+B model.
REQ-037 A=4'h5, B=4'h3, out_ready=1 -> out_valid in cycle 13, out_sum=4'h8, out_cy=0.
REQ-038 A=4'hF, B=4'h1 -> out_sum=4'h0, out_cy=1.
REQ-039 Back-to-back A=F,B=F then A=0,B=0 -> 4'hE/cy=1, then 4'h0/cy=0 (proves the carry is flushed between operations).
REQ-040 out_ready held low 5 cycles in DONE -> out_valid stays 1, out_sum/out_cy stable, in_ready=0 with in_valid=1; release -> IDLE next cycle.
REQ-041 rst pulsed low in ADD cycle 2 -> immediate IDLE, out_valid=0, all outputs at reset values; next op A=2,B=2 -> out_sum=4'h4, out_cy=0.
REQ-042 Random sweep of all 256 A/B pairs with random out_ready stalls -> all results match, with zero protocol violations.
